// File: rtl/led_trail_pwm.sv
// led_trail_pwm: drives LEDs from a one-hot position with a PWM fading comet tail and flags malformed positions
module led_trail_pwm #(
    parameter int N          = 4,
    parameter int PWM_W      = 8,
    parameter int DECAY_DIV  = 50000,
    parameter int DECAY_STEP = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] pos_i,
    output logic [N-1:0] led_o,
    output logic         step_o,
    output logic         err_o
);
    localparam int DIV_W = $clog2(DECAY_DIV);
    localparam logic [PWM_W-1:0] MAX = '1;
    localparam logic [PWM_W-1:0] STEP = PWM_W'(DECAY_STEP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);

    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [PWM_W-1:0] bright_q [N];
    logic [PWM_W-1:0] bright_d [N];
    logic [N-1:0]     pos_q, led_q, led_d;
    logic             step_q, err_q, tick, one_hot;

    // counters: free-running PWM ramp and decay-tick divider that only runs while displaying
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        tick      = en && (div_cnt_q == DIV_LAST);
        div_cnt_d = (!en || tick) ? '0 : div_cnt_q + 1'b1;
        one_hot   = (pos_i != '0) && ((pos_i & (pos_i - 1'b1)) == '0);
    end

    // per-LED brightness (active LED pinned at MAX, others fade and saturate at 0) and PWM compare
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bright_d[i] = !en      ? '0 :
                          pos_i[i] ? MAX :
                          !tick    ? bright_q[i] :
                          (bright_q[i] >= STEP) ? bright_q[i] - STEP : '0;
            led_d[i]    = en & (pos_i[i] | (pwm_cnt_q < bright_q[i]));
        end
    end

    // state and registered outputs; reset clears the whole trail at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            div_cnt_q <= '0;
            pos_q     <= '0;
            led_q     <= '0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < N; i++) bright_q[i] <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            pos_q     <= pos_i;
            led_q     <= led_d;
            step_q    <= (pos_i != pos_q);
            err_q     <= !one_hot;
            for (int i = 0; i < N; i++) bright_q[i] <= bright_d[i];
        end
    end

    assign led_o  = led_q;
    assign step_o = step_q;
    assign err_o  = err_q;
endmodule
